uart_key_rx: RTL
================

// Module: uart_key_rx
// PURPOSE
//  Serial keyboard front end for the ATM input path. Receives 8N1 UART bytes from the
//  host terminal on the board's USB-UART rx pin and turns each byte into one ASCII key event.
//  Each key is presented on ascii_code for HOLD_CYCLES clocks, then ascii_code returns to IDLE_CODE.
//  The downstream user_input stage samples ascii_code every clock, so one keystroke is seen once.
// PARAMETERS
//  CLK_FREQ     100000000  system clock frequency in Hz
//  BAUD         115200     serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), must be >= 4
//  IDLE_CODE    8'h2A      value driven on ascii_code when no key is presented ('*')
//  HOLD_CYCLES  1          clocks each received character is held on ascii_code (>= 1)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  asynchronous, active-high reset
//  rx          in   1  raw serial line (idle high), asynchronous to clk
//  ascii_code  out  8  received character during hold window, else IDLE_CODE
//  key_valid   out  1  high for exactly the first cycle of each hold window
//  frame_err   out  1  one-cycle pulse when a stop bit samples low
//  rx_busy     out  1  high while FSM is not in IDLE
// BEHAVIOUR
//  Reset: ascii_code=IDLE_CODE, key_valid=0, frame_err=0, rx_busy=0, FSM=IDLE.
//   Synchronizer flops reset to 1. Bit and baud counters reset to 0. Hold counter resets to 0.
//   Reset mid-frame discards the partial byte; after release the FSM waits for a fresh start bit.
//  Input: rx passes through a 2-flop synchronizer (rx_s). The FSM uses only rx_s.
//  FSM states and transitions:
//   IDLE : on rx_s==0, clear the baud counter and go to START.
//   START: at count CLKS_PER_BIT/2, sample rx_s.
//          Sample 0 -> reset the counter and go to DATA with bit index 0.
//          Sample 1 -> treat as a glitch and return to IDLE. No output in either case.
//   DATA : every CLKS_PER_BIT clocks, sample rx_s into shift reg bit [index], LSB first.
//          After bit 7 go to STOP.
//   STOP : after CLKS_PER_BIT clocks, sample rx_s.
//          Sample 1 -> load char and go to IDLE.
//          Sample 0 -> pulse frame_err, discard byte and go to BREAK.
//   BREAK: stay until rx_s==1, then go to IDLE. Holding the line low yields exactly one frame_err.
//  Presentation:
//   - Char is loaded the cycle after the stop sample. ascii_code=char and key_valid=1 are
//     registered outputs, visible on the next clock edge.
//   - Hold counter keeps ascii_code=char for HOLD_CYCLES cycles, then ascii_code=IDLE_CODE.
//   - key_valid is high only in the first hold cycle.
//   - If a new char loads while a hold is active, the new char replaces the old one,
//     the hold restarts and key_valid pulses again.
//   - A received IDLE_CODE byte still pulses key_valid; ascii_code stays 8'h2A.
//  Latency: about 9.5 bit times from the start-bit falling edge, plus 2 sync clocks,
//   plus 1 clock, to key_valid.
//  No byte filtering or case conversion: every byte is passed through unchanged.
//  Enter (8'h0D) and 'q' (8'h71) are handled by the consumer.
// TESTING  (CLK_FREQ=1600000, BAUD=100000 -> 16 clk/bit, HOLD_CYCLES=1)
//  1. Drive frame for 8'h31 -> ascii_code=8'h31 for exactly 1 cycle with key_valid=1,
//     then 8'h2A; frame_err stays 0.
//  2. rx low for 3 clks, then high -> START rejects the glitch; no key_valid, rx_busy drops
//     within 10 clks, ascii_code stays 8'h2A.
//  3. Frame 8'h0D with stop bit 0 -> frame_err pulses 1 cycle, no key_valid,
//     ascii_code stays 8'h2A.
//  4. Back-to-back '1','2','3','4',8'h0D (no idle gap) -> five key_valid pulses in order,
//     160 clks apart, with the correct codes.
//  5. Assert rst during DATA bit 4 of 8'h62 -> outputs return to reset values immediately;
//     the following 8'h77 frame is received correctly.
//  6. Hold rx low for 30 bit times, then release and send 8'h71 -> one frame_err,
//     then a single key_valid with 8'h71.

Source files
------------

// File: rtl/uart_key_rx_if.sv
// Serial key receiver bus: raw rx line in, key event and status out.
// Combinational bundle only; no latency of its own.
// No backpressure: the consumer must sample ascii_code every clock.
interface uart_key_rx_if;
  logic       rx;
  logic [7:0] ascii_code;
  logic       key_valid;
  logic       frame_err;
  logic       rx_busy;

  // Host side drives the serial line and observes key events
  modport master (output rx, input ascii_code, key_valid, frame_err, rx_busy);
  // Receiver side consumes the line and produces key events
  modport slave  (input rx, output ascii_code, key_valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_key_rx.sv
// 8N1 UART receiver turning each byte into a held ASCII key event.
// Latency: ~9.5 bit times from start edge + 2 sync clocks + 1 presentation clock.
// No backpressure: a new key replaces one still being held.
module uart_key_rx #(
  parameter int         CLK_FREQ    = 100000000,
  parameter int         BAUD        = 115200,
  parameter logic [7:0] IDLE_CODE   = 8'h2A,
  parameter int         HOLD_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_key_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    char_reg;
  logic          load;
  logic [HW-1:0] hold_cnt;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM: start validation, LSB-first data capture, stop check, break wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      char_reg      <= '0;
      load          <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.rx_busy   <= 1'b0;
    end else begin
      load          <= 1'b0;
      bus.frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt         <= '0;
            state       <= S_START;
            bus.rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              idx   <= '0;
              state <= S_DATA;
            end else begin
              // Start bit did not hold to mid-bit: a glitch, not a frame
              state       <= S_IDLE;
              bus.rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              char_reg    <= shift;
              load        <= 1'b1;
              state       <= S_IDLE;
              bus.rx_busy <= 1'b0;
            end else begin
              // Low stop bit: drop the byte and wait out the break so a held-low
              // line reports only one error
              bus.frame_err <= 1'b1;
              state         <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state       <= S_IDLE;
            bus.rx_busy <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          bus.rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Presentation: hold each new char for HOLD_CYCLES clocks, flag its first cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ascii_code <= IDLE_CODE;
      bus.key_valid  <= 1'b0;
      hold_cnt       <= '0;
    end else begin
      bus.key_valid <= 1'b0;
      if (load) begin
        bus.ascii_code <= char_reg;
        bus.key_valid  <= 1'b1;
        hold_cnt       <= HOLD_LOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HOLD_ONE) begin
          bus.ascii_code <= IDLE_CODE;
        end
      end
    end
  end

endmodule
